// File: rtl/cdc_pkg.sv
// Shared definitions for the req/ack clock-domain-crossing handshake blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cdc_pkg;

    // Handshake protocol selection.
    localparam int MODE_TWO_PHASE  = 0;
    localparam int MODE_FOUR_PHASE = 1;

    // Legal request synchroniser depths.
    localparam int NB_SYNC_MIN = 2;
    localparam int NB_SYNC_MAX = 4;

    // Receive FSM. RELEASE is only reached in four-phase mode.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchroniser for signals arriving from a foreign clock domain.
// Latency: NB_SYNC cycles from stage 0 sample to o_q.
// Backpressure: none; samples every cycle.
module sync_chain #(
    parameter int NB_IN   = 1,
    parameter int NB_SYNC = 2
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [NB_IN-1:0] i_d,
    output logic [NB_IN-1:0] o_q
);

    logic [NB_SYNC-1:0][NB_IN-1:0] stage_q;
    logic [NB_SYNC-1:0][NB_IN-1:0] stage_d;

    // Shift the async input one stage further each cycle.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = i_d;
        for (int i = 1; i < NB_SYNC; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Chain registers, cleared by synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign o_q = stage_q[NB_SYNC-1];

endmodule

// File: rtl/cdc_handshake_rx.sv
// Receive side of a req/ack CDC handshake: captures a wide bus once per request, offers it valid/ready.
// Latency: NB_SYNC+1 cycles from request change to o_valid; ack follows the accepting edge.
// Backpressure: word held in o_data until i_ready; ack withheld so the sender stalls.
module cdc_handshake_rx #(
    parameter int NB_DATA  = 8,
    parameter int NB_SYNC  = 2,
    parameter int MODE     = 0,
    parameter int NB_COUNT = 16
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_req,
    input  logic [NB_DATA-1:0]  i_data,
    output logic                o_ack,
    output logic [NB_DATA-1:0]  o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_proto_err,
    output logic [NB_COUNT-1:0] o_xfer_count
);

    import cdc_pkg::*;

    if (NB_SYNC < NB_SYNC_MIN || NB_SYNC > NB_SYNC_MAX) begin : g_bad_sync
        $error("cdc_handshake_rx: NB_SYNC must be within 2..4");
    end
    if (MODE != MODE_TWO_PHASE && MODE != MODE_FOUR_PHASE) begin : g_bad_mode
        $error("cdc_handshake_rx: MODE must be 0 or 1");
    end

    localparam bit FOUR_PHASE = (MODE == MODE_FOUR_PHASE);

    logic                req_s;
    state_t              state_q,  state_d;
    logic                ref_q,    ref_d;
    logic                ack_q,    ack_d;
    logic [NB_DATA-1:0]  data_q,   data_d;
    logic                valid_q,  valid_d;
    logic                err_q,    err_d;
    logic [NB_COUNT-1:0] count_q,  count_d;
    logic                new_req;
    logic                req_bad;
    logic                accept;

    // Only the synchronised request is ever looked at; i_data is sampled once, in the capture cycle.
    sync_chain #(
        .NB_IN   (1),
        .NB_SYNC (NB_SYNC)
    ) u_req_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_d     (i_req),
        .o_q     (req_s)
    );

    // Protocol decode: what counts as a new request, and what counts as a violation while holding.
    always_comb begin
        new_req = 1'b0;
        req_bad = 1'b0;
        if (FOUR_PHASE) begin
            new_req = req_s;
            req_bad = !req_s;
        end else begin
            new_req = (req_s != ref_q);
            req_bad = (req_s != ref_q);
        end
        accept = valid_q && i_ready;
    end

    // Next-state and output update for the capture / hold / release sequence.
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        ack_d   = ack_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (new_req) begin
                    data_d  = i_data;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                    if (!FOUR_PHASE) begin
                        ref_d = req_s;
                    end
                end
            end
            ST_HOLD: begin
                // A violation is only flagged; the held word and the FSM carry on untouched.
                if (req_bad) begin
                    err_d = 1'b1;
                end
                if (accept) begin
                    valid_d = 1'b0;
                    count_d = count_q + NB_COUNT'(1);
                    if (FOUR_PHASE) begin
                        ack_d   = 1'b1;
                        state_d = ST_RELEASE;
                    end else begin
                        ack_d   = ~ack_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RELEASE: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any held word without acknowledging it.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            ref_q   <= 1'b0;
            ack_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign o_ack        = ack_q;
    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_proto_err  = err_q;
    assign o_xfer_count = count_q;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Directed bench for cdc_handshake_rx: two-phase, four-phase and narrow-counter instances.
// Latency: checks exact edge timing of o_valid / o_ack against hand-derived edge numbers.
// Backpressure: exercised by holding i_ready low and by a random ready pattern.
module tb_cdc_handshake_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // dut0: MODE 0, NB_SYNC 2, NB_COUNT 16
    logic        rst0, req0, ack0, v0, rdy0, err0;
    logic [7:0]  d0, od0;
    logic [15:0] cnt0;
    // dut1: MODE 1, NB_SYNC 3, NB_COUNT 16
    logic        rst1, req1, ack1, v1, rdy1, err1;
    logic [7:0]  d1, od1;
    logic [15:0] cnt1;
    // dut2: MODE 0, NB_SYNC 2, NB_COUNT 4
    logic        rst2, req2, ack2, v2, rdy2, err2;
    logic [7:0]  d2, od2;
    logic [3:0]  cnt2;

    cdc_handshake_rx #(.NB_DATA(8), .NB_SYNC(2), .MODE(0), .NB_COUNT(16)) u_dut0 (
        .i_clock(clk), .i_reset(rst0), .i_req(req0), .i_data(d0), .o_ack(ack0), .o_data(od0),
        .o_valid(v0), .i_ready(rdy0), .o_proto_err(err0), .o_xfer_count(cnt0));

    cdc_handshake_rx #(.NB_DATA(8), .NB_SYNC(3), .MODE(1), .NB_COUNT(16)) u_dut1 (
        .i_clock(clk), .i_reset(rst1), .i_req(req1), .i_data(d1), .o_ack(ack1), .o_data(od1),
        .o_valid(v1), .i_ready(rdy1), .o_proto_err(err1), .o_xfer_count(cnt1));

    cdc_handshake_rx #(.NB_DATA(8), .NB_SYNC(2), .MODE(0), .NB_COUNT(4)) u_dut2 (
        .i_clock(clk), .i_reset(rst2), .i_req(req2), .i_data(d2), .o_ack(ack2), .o_data(od2),
        .o_valid(v2), .i_ready(rdy2), .o_proto_err(err2), .o_xfer_count(cnt2));

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
        d0 = 8'h00; d1 = 8'h00; d2 = 8'h00;
        rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
        @(posedge clk); #1;                           // after edge 1
        checks++;
        if (v0 !== 1'b0 || ack0 !== 1'b0 || od0 !== 8'h00 || err0 !== 1'b0 || cnt0 !== 16'd0) begin
            errors++;
            $display("FAIL reset_dut0: v=%b ack=%b data=%h err=%b cnt=%0d, expected all zero", v0, ack0, od0, err0, cnt0);
        end
        checks++;
        if (v1 !== 1'b0 || ack1 !== 1'b0 || od1 !== 8'h00 || err1 !== 1'b0 || cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL reset_dut1: v=%b ack=%b data=%h err=%b cnt=%0d, expected all zero", v1, ack1, od1, err1, cnt1);
        end
        checks++;
        if (v2 !== 1'b0 || ack2 !== 1'b0 || od2 !== 8'h00 || err2 !== 1'b0 || cnt2 !== 4'd0) begin
            errors++;
            $display("FAIL reset_dut2: v=%b ack=%b data=%h err=%b cnt=%0d, expected all zero", v2, ack2, od2, err2, cnt2);
        end
        repeat (2) @(posedge clk);
        #1;                                           // after edge 3
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    endtask

    task automatic test_single_mode0();
        d0 = 8'hA5;
        repeat (6) @(posedge clk);
        #1;
        req0 = 1'b1;                                  // between edges 9 and 10
        for (int e = 10; e <= 11; e++) begin
            @(posedge clk); #1;
            checks++;
            if (v0 !== 1'b0) begin
                errors++;
                $display("FAIL single_early_valid: edge %0d v=%b expected 0", e, v0);
            end
        end
        @(posedge clk); #1;                           // edge 12
        checks++;
        if (v0 !== 1'b1 || od0 !== 8'hA5 || ack0 !== 1'b0) begin
            errors++;
            $display("FAIL single_capture: v=%b data=%h ack=%b, expected v=1 data=a5 ack=0", v0, od0, ack0);
        end
        @(posedge clk); #1;                           // edge 13
        checks++;
        if (ack0 !== 1'b1 || cnt0 !== 16'd1 || v0 !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: ack=%b cnt=%0d v=%b, expected ack=1 cnt=1 v=0", ack0, cnt0, v0);
        end
    endtask

    task automatic test_backpressure_mode0();
        int n;
        bit bad;
        rdy0 = 1'b0; d0 = 8'h3C; req0 = 1'b0;
        n = 0;
        while (v0 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (v0 !== 1'b1) begin
            errors++;
            $display("FAIL bp_valid_timeout: v=%b expected 1", v0);
        end
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (v0 !== 1'b1 || od0 !== 8'h3C || ack0 !== 1'b1 || cnt0 !== 16'd1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: v=%b data=%h ack=%b cnt=%0d, expected v=1 data=3c ack=1 cnt=1", v0, od0, ack0, cnt0);
        end
        rdy0 = 1'b1;
        @(posedge clk); #1;
        rdy0 = 1'b0;
        checks++;
        if (ack0 !== 1'b0 || cnt0 !== 16'd2 || v0 !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: ack=%b cnt=%0d v=%b, expected ack=0 cnt=2 v=0", ack0, cnt0, v0);
        end
    endtask

    task automatic test_proto_err_mode0();
        int n;
        rdy0 = 1'b0; d0 = 8'h77; req0 = 1'b1;
        n = 0;
        while (v0 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (v0 !== 1'b1 || od0 !== 8'h77 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL perr0_capture: v=%b data=%h err=%b, expected v=1 data=77 err=0", v0, od0, err0);
        end
        d0 = 8'h88; req0 = 1'b0;                      // second toggle before ack
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (err0 !== 1'b1 || v0 !== 1'b1 || od0 !== 8'h77 || ack0 !== 1'b0 || cnt0 !== 16'd2) begin
            errors++;
            $display("FAIL perr0_flag: err=%b v=%b data=%h ack=%b cnt=%0d, expected err=1 v=1 data=77 ack=0 cnt=2",
                     err0, v0, od0, ack0, cnt0);
        end
    endtask

    task automatic test_reset_mid_mode0();
        int n;
        rst0 = 1'b1; req0 = 1'b0; d0 = 8'h00;        // sender is reset together with the block
        @(posedge clk); #1;
        rst0 = 1'b0;
        checks++;
        if (v0 !== 1'b0 || ack0 !== 1'b0 || cnt0 !== 16'd0 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear: v=%b ack=%b cnt=%0d err=%b, expected all zero", v0, ack0, cnt0, err0);
        end
        rdy0 = 1'b1; d0 = 8'hC3; req0 = 1'b1;
        n = 0;
        while (ack0 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (ack0 !== 1'b1 || od0 !== 8'hC3 || cnt0 !== 16'd1 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_fresh: ack=%b data=%h cnt=%0d err=%b, expected ack=1 data=c3 cnt=1 err=0",
                     ack0, od0, cnt0, err0);
        end
    endtask

    task automatic test_four_phase();
        rdy1 = 1'b1;
        @(posedge clk); #1;
        d1 = 8'h5A; req1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (v1 !== 1'b0) begin
            errors++;
            $display("FAIL fp_early_valid: v=%b expected 0 three edges after req", v1);
        end
        @(posedge clk); #1;
        checks++;
        if (v1 !== 1'b1 || od1 !== 8'h5A || ack1 !== 1'b0) begin
            errors++;
            $display("FAIL fp_capture: v=%b data=%h ack=%b, expected v=1 data=5a ack=0", v1, od1, ack1);
        end
        @(posedge clk); #1;
        checks++;
        if (ack1 !== 1'b1 || v1 !== 1'b0 || cnt1 !== 16'd1) begin
            errors++;
            $display("FAIL fp_ack_rise: ack=%b v=%b cnt=%0d, expected ack=1 v=0 cnt=1", ack1, v1, cnt1);
        end
        req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ack1 !== 1'b1) begin
            errors++;
            $display("FAIL fp_ack_hold: ack=%b expected 1 three edges after req fall", ack1);
        end
        @(posedge clk); #1;
        checks++;
        if (ack1 !== 1'b0 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL fp_ack_fall: ack=%b err=%b, expected ack=0 err=0", ack1, err1);
        end
    endtask

    task automatic test_proto_err_mode1();
        int n;
        rdy1 = 1'b0; d1 = 8'h66; req1 = 1'b1;
        n = 0;
        while (v1 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        req1 = 1'b0;                                  // withdrawn before ack
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (err1 !== 1'b1 || v1 !== 1'b1 || od1 !== 8'h66) begin
            errors++;
            $display("FAIL perr1_flag: err=%b v=%b data=%h, expected err=1 v=1 data=66", err1, v1, od1);
        end
        rdy1 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ack1 !== 1'b1 || cnt1 !== 16'd2 || err1 !== 1'b1) begin
            errors++;
            $display("FAIL perr1_sticky: ack=%b cnt=%0d err=%b, expected ack=1 cnt=2 err=1", ack1, cnt1, err1);
        end
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
    endtask

    task automatic test_back_to_back_mode1();
        int n;
        logic [7:0] w8;
        rdy1 = 1'b1;
        for (int w = 0; w < 10; w++) begin
            w8 = 8'(w);
            d1 = w8; req1 = 1'b1;
            n = 0;
            while (ack1 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
            checks++;
            if (ack1 !== 1'b1 || od1 !== w8) begin
                errors++;
                $display("FAIL b2b_word: idx %0d ack=%b data=%h, expected ack=1 data=%h", w, ack1, od1, w8);
            end
            req1 = 1'b0;
            n = 0;
            while (ack1 !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
        end
        checks++;
        if (cnt1 !== 16'd10 || err1 !== 1'b0 || ack1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: cnt=%0d err=%b ack=%b, expected cnt=10 err=0 ack=0", cnt1, err1, ack1);
        end
    endtask

    task automatic test_counter_wrap();
        int n;
        rdy2 = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            d2 = 8'(i);
            req2 = ~req2;
            n = 0;
            while (ack2 !== req2 && n < 30) begin @(posedge clk); #1; n++; end
            if (i == 15 || i == 16) begin
                checks++;
                if (cnt2 !== 4'(i)) begin
                    errors++;
                    $display("FAIL wrap_mid: after %0d transfers cnt=%0d expected %0d", i, cnt2, 4'(i));
                end
            end
        end
        checks++;
        if (cnt2 !== 4'd1 || err2 !== 1'b0 || ack2 !== req2) begin
            errors++;
            $display("FAIL wrap_final: cnt=%0d err=%b ack=%b, expected cnt=1 err=0 ack=%b", cnt2, err2, ack2, req2);
        end
    endtask

    task automatic test_random_mode0();
        int  got;
        bit  sender_done;
        bit  timed_out;
        logic [7:0] exp_b;
        rst0 = 1'b1; req0 = 1'b0; rdy0 = 1'b0;
        @(posedge clk); #1;
        rst0 = 1'b0;
        got = 0; sender_done = 1'b0; timed_out = 1'b0;
        fork
            begin : sender
                int n;
                for (int w = 0; w < 1000; w++) begin
                    repeat ($urandom_range(0, 5)) @(posedge clk);
                    #($urandom_range(1, 8));
                    d0 = 8'(w * 37 + 11);
                    req0 = ~req0;
                    n = 0;
                    while (ack0 !== req0 && n < 200) begin @(posedge clk); #1; n++; end
                    if (ack0 !== req0) begin
                        timed_out = 1'b1;
                        break;
                    end
                end
                sender_done = 1'b1;
            end
            begin : consumer
                while (got < 1000 && !sender_done) begin
                    @(negedge clk);
                    rdy0 = 1'($urandom_range(0, 1));
                    if (v0 === 1'b1 && rdy0) begin
                        exp_b = 8'(got * 37 + 11);
                        checks++;
                        if (od0 !== exp_b) begin
                            errors++;
                            $display("FAIL rand_word: idx %0d data=%h expected %h", got, od0, exp_b);
                        end
                        got++;
                    end
                end
            end
        join
        checks++;
        if (timed_out || got != 1000 || err0 !== 1'b0 || cnt0 !== 16'd1000) begin
            errors++;
            $display("FAIL rand_summary: timeout=%b words=%0d err=%b cnt=%0d, expected timeout=0 words=1000 err=0 cnt=1000",
                     timed_out, got, err0, cnt0);
        end
    endtask

    initial begin
        test_reset();
        test_single_mode0();
        test_backpressure_mode0();
        test_proto_err_mode0();
        test_reset_mid_mode0();
        test_four_phase();
        test_proto_err_mode1();
        test_back_to_back_mode1();
        test_counter_wrap();
        test_random_mode0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
